spiker_writer: RTL and testbench

SPIKER_WRITER -- requirements
Module: spiker_writer

---
 rtl/spiker_writer.sv | 140 ++++++++++++++
 tb/tb_spiker_writer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spiker_writer.sv
// Output-spike accumulator: counts per-neuron spikes over N_STEPS handshakes,
// then streams the N_OUT counts to the register file and raises a done status.
module spiker_writer #(
    parameter int WIDTH   = 32,
    parameter int N_OUT   = 10,
    parameter int N_STEPS = 25,
    parameter int CNT_W   = 16,
    localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             test_mode_i,
    input  logic             start_i,
    input  logic [N_OUT-1:0] spikes_i,
    input  logic             spikes_valid_i,
    output logic             spikes_ready_o,
    output logic [WIDTH-1:0] res_data_o,
    output logic [IDX_W-1:0] res_idx_o,
    output logic             res_de_o,
    output logic             done_o,
    output logic             done_de_o,
    input  logic             done_clr_i,
    output logic             busy_o
);

    localparam int STEP_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_OUT - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [N_OUT];
    logic [CNT_W-1:0]   cnt_d [N_OUT];
    logic [STEP_W-1:0]  step_q, step_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               de_q, de_d;
    logic               done_q, done_d;
    logic               done_de_q, done_de_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               unused_test_mode;

    assign unused_test_mode = test_mode_i;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        if (inc && (c != {CNT_W{1'b1}})) return c + CNT_W'(1);
        return c;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        idx_d     = idx_q;
        data_d    = data_q;
        de_d      = 1'b0;
        done_d    = done_q;
        done_de_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ACCUM;
                    step_d  = '0;
                    for (int i = 0; i < N_OUT; i++) cnt_d[i] = '0;
                end
            end
            ACCUM: begin
                if (spikes_valid_i && ready_q) begin
                    for (int i = 0; i < N_OUT; i++) cnt_d[i] = sat_inc(cnt_q[i], spikes_i[i]);
                    step_d = step_q + STEP_W'(1);
                    // The final step goes straight into the first result write.
                    if (step_q == LAST_STEP) begin
                        state_d = WRITE;
                        idx_d   = '0;
                        data_d  = WIDTH'(cnt_d[0]);
                        de_d    = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    done_de_d = 1'b1;
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    data_d = WIDTH'(cnt_q[idx_d]);
                    de_d   = 1'b1;
                end
            end
            DONE: begin
                if (done_clr_i) begin
                    state_d   = IDLE;
                    done_d    = 1'b0;
                    done_de_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == ACCUM);
        busy_d  = (state_d == ACCUM) || (state_d == WRITE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            step_q    <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            de_q      <= 1'b0;
            done_q    <= 1'b0;
            done_de_q <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            de_q      <= de_d;
            done_q    <= done_d;
            done_de_q <= done_de_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign spikes_ready_o = ready_q;
    assign res_data_o     = data_q;
    assign res_idx_o      = idx_q;
    assign res_de_o       = de_q;
    assign done_o         = done_q;
    assign done_de_o      = done_de_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_spiker_writer.sv
// Bench for spiker_writer: a default instance and a CNT_W=4 instance share stimulus
// and are checked against per-neuron spike totals kept by the bench.
module tb_spiker_writer;

    localparam int NO = 10;
    localparam int NS = 25;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          test_mode = 1'b0;
    logic          start = 1'b0;
    logic [NO-1:0] spikes = '0;
    logic          valid = 1'b0;
    logic          done_clr = 1'b0;

    logic          a_ready, a_de, a_done, a_done_de, a_busy;
    logic [31:0]   a_data;
    logic [3:0]    a_idx;
    logic          b_ready, b_de, b_done, b_done_de, b_busy;
    logic [31:0]   b_data;
    logic [3:0]    b_idx;

    int errors = 0;
    int checks = 0;
    int exp_cnt [NO];

    always #5 clk = ~clk;

    spiker_writer dut_a (
        .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode), .start_i(start),
        .spikes_i(spikes), .spikes_valid_i(valid), .spikes_ready_o(a_ready),
        .res_data_o(a_data), .res_idx_o(a_idx), .res_de_o(a_de), .done_o(a_done),
        .done_de_o(a_done_de), .done_clr_i(done_clr), .busy_o(a_busy)
    );

    spiker_writer #(.CNT_W(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode), .start_i(start),
        .spikes_i(spikes), .spikes_valid_i(valid), .spikes_ready_o(b_ready),
        .res_data_o(b_data), .res_idx_o(b_idx), .res_de_o(b_de), .done_o(b_done),
        .done_de_o(b_done_de), .done_clr_i(done_clr), .busy_o(b_busy)
    );

    function automatic int satv(input int c, input int w);
        return (c > (1 << w) - 1) ? (1 << w) - 1 : c;
    endfunction

    // Drives IDLE noise, a start pulse and NS handshakes; returns at the first WRITE cycle.
    // mode 0: only neuron 0 fires, 1: random, 2: all fire.
    task automatic accumulate(input int mode, input int max_gap, input bit start_noise);
        logic [NO-1:0] v;
        for (int j = 0; j < NO; j++) exp_cnt[j] = 0;
        repeat (2) begin
            valid = 1'b1; spikes = NO'($urandom); done_clr = 1'b1;
            @(negedge clk);
            checks++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0)
                begin errors++; $display("FAIL idle_ready a=%b b=%b exp=0", a_ready, b_ready); end
        end
        valid = 1'b0; done_clr = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < NS; s++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                spikes = NO'($urandom);
                if (start_noise) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            case (mode)
                0:       v = NO'(1);
                2:       v = '1;
                default: v = NO'($urandom);
            endcase
            checks++;
            if (a_ready !== 1'b1 || b_ready !== 1'b1 || a_busy !== 1'b1)
                begin errors++; $display("FAIL accum_ready step=%0d a=%b b=%b busy=%b exp=1", s, a_ready, b_ready, a_busy); end
            spikes = v; valid = 1'b1;
            if (start_noise) start = 1'b1;
            @(negedge clk);
            valid = 1'b0; start = 1'b0;
            for (int j = 0; j < NO; j++) exp_cnt[j] += int'(v[j]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_ready, a_de, a_done, a_done_de, a_busy, a_data, a_idx} !== '0 ||
            {b_ready, b_de, b_done, b_done_de, b_busy, b_data, b_idx} !== '0)
            begin errors++; $display("FAIL reset_outputs a_data=%0d a_idx=%0d a_busy=%b exp=all zero", a_data, a_idx, a_busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        accumulate(0, 0, 1'b0);
        for (int k = 0; k < NO; k++) begin
            checks++;
            if (a_de !== 1'b1 || a_idx !== 4'(k) || a_data !== 32'(exp_cnt[k]) || a_busy !== 1'b1)
                begin errors++; $display("FAIL basic_wr_a k=%0d de=%b idx=%0d data=%0d exp=%0d", k, a_de, a_idx, a_data, exp_cnt[k]); end
            checks++;
            if (b_de !== 1'b1 || b_idx !== 4'(k) || b_data !== 32'(satv(exp_cnt[k], 4)))
                begin errors++; $display("FAIL basic_wr_b k=%0d de=%b idx=%0d data=%0d exp=%0d", k, b_de, b_idx, b_data, satv(exp_cnt[k], 4)); end
            @(negedge clk);
        end
        checks++;
        if (a_de !== 1'b0 || a_done !== 1'b1 || a_done_de !== 1'b1 || a_busy !== 1'b0 || b_done !== 1'b1)
            begin errors++; $display("FAIL basic_done de=%b done=%b done_de=%b busy=%b exp=0110", a_de, a_done, a_done_de, a_busy); end
        @(negedge clk);
        checks++;
        if (a_done !== 1'b1 || a_done_de !== 1'b0 || b_done_de !== 1'b0)
            begin errors++; $display("FAIL basic_done_pulse done=%b done_de=%b exp=1,0", a_done, a_done_de); end
    endtask

    task automatic test_done_clear_with_start();
        done_clr = 1'b1; start = 1'b1;
        @(negedge clk);
        done_clr = 1'b0; start = 1'b0;
        checks++;
        if (a_done !== 1'b0 || a_done_de !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b0)
            begin errors++; $display("FAIL clr_state done=%b done_de=%b busy=%b ready=%b exp=0100", a_done, a_done_de, a_busy, a_ready); end
        repeat (4) @(negedge clk);
        checks++;
        if (a_ready !== 1'b0 || a_busy !== 1'b0 || a_done_de !== 1'b0 || b_busy !== 1'b0)
            begin errors++; $display("FAIL clr_stays_idle ready=%b busy=%b done_de=%b exp=000", a_ready, a_busy, a_done_de); end
    endtask

    task automatic test_valid_gaps();
        accumulate(1, 3, 1'b0);
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0)
            begin errors++; $display("FAIL gaps_ready_drop a=%b b=%b exp=0", a_ready, b_ready); end
        for (int k = 0; k < NO; k++) begin
            checks++;
            if (a_de !== 1'b1 || a_idx !== 4'(k) || a_data !== 32'(exp_cnt[k]))
                begin errors++; $display("FAIL gaps_wr_a k=%0d de=%b idx=%0d data=%0d exp=%0d", k, a_de, a_idx, a_data, exp_cnt[k]); end
            checks++;
            if (b_de !== 1'b1 || b_data !== 32'(satv(exp_cnt[k], 4)))
                begin errors++; $display("FAIL gaps_wr_b k=%0d de=%b data=%0d exp=%0d", k, b_de, b_data, satv(exp_cnt[k], 4)); end
            @(negedge clk);
        end
        checks++;
        if (a_de !== 1'b0 || a_done !== 1'b1 || a_done_de !== 1'b1)
            begin errors++; $display("FAIL gaps_done de=%b done=%b done_de=%b exp=0,1,1", a_de, a_done, a_done_de); end
        done_clr = 1'b1;
        @(negedge clk);
        done_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        accumulate(2, 1, 1'b0);
        for (int k = 0; k < NO; k++) begin
            checks++;
            if (b_de !== 1'b1 || b_idx !== 4'(k) || b_data !== 32'd15)
                begin errors++; $display("FAIL sat_wr_b k=%0d de=%b idx=%0d data=%0d exp=15", k, b_de, b_idx, b_data); end
            checks++;
            if (a_de !== 1'b1 || a_data !== 32'(NS))
                begin errors++; $display("FAIL sat_wr_a k=%0d de=%b data=%0d exp=%0d", k, a_de, a_data, NS); end
            @(negedge clk);
        end
        done_clr = 1'b1;
        @(negedge clk);
        done_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        accumulate(1, 2, 1'b1);
        for (int k = 0; k < NO; k++) begin
            checks++;
            if (a_de !== 1'b1 || a_idx !== 4'(k) || a_data !== 32'(exp_cnt[k]))
                begin errors++; $display("FAIL start_ign_wr_a k=%0d de=%b idx=%0d data=%0d exp=%0d", k, a_de, a_idx, a_data, exp_cnt[k]); end
            checks++;
            if (b_de !== 1'b1 || b_data !== 32'(satv(exp_cnt[k], 4)))
                begin errors++; $display("FAIL start_ign_wr_b k=%0d de=%b data=%0d exp=%0d", k, b_de, b_data, satv(exp_cnt[k], 4)); end
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (a_done !== 1'b1 || a_de !== 1'b0 || a_done_de !== 1'b1)
            begin errors++; $display("FAIL start_ign_done done=%b de=%b done_de=%b exp=1,0,1", a_done, a_de, a_done_de); end
        repeat (2) begin
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b0)
            begin errors++; $display("FAIL start_in_done done=%b busy=%b ready=%b exp=1,0,0", a_done, a_busy, a_ready); end
    endtask

    task automatic test_reset_mid_write();
        int bad;
        accumulate(1, 1, 1'b0);
        for (int k = 0; k <= 4; k++) begin
            checks++;
            if (a_de !== 1'b1 || a_idx !== 4'(k) || a_data !== 32'(exp_cnt[k]))
                begin errors++; $display("FAIL rstw_wr_a k=%0d de=%b idx=%0d data=%0d exp=%0d", k, a_de, a_idx, a_data, exp_cnt[k]); end
            if (k < 4) @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (a_de !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b0 || a_data !== 32'd0 || a_idx !== 4'd0 || b_de !== 1'b0)
            begin errors++; $display("FAIL rstw_async de=%b done=%b busy=%b data=%0d idx=%0d exp=all zero", a_de, a_done, a_busy, a_data, a_idx); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_de !== 1'b0 || b_de !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0)
            begin errors++; $display("FAIL rstw_no_writes bad_cycles=%0d exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_done_clear_with_start();
        test_basic();
        test_done_clear_with_start();
        test_valid_gaps();
        test_saturation();
        test_start_ignored();
        test_done_clear_with_start();
        test_reset_mid_write();
        test_basic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
